// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin, LSB first) built from one full-subtractor cell.
// Optional SERIAL_SUB_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             borrow,
  output logic             ovf
`else
  output logic             borrow
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_br;
  logic [CW-1:0]    r_count;

  logic             w_d;
  logic             w_bo;

  // Full-subtractor cell on the current operand LSBs and the carried borrow
  assign w_d  = r_a[0] ^ r_b[0] ^ r_br;
  assign w_bo = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_br    <= 1'b0;
      r_count <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_acc   <= '0;
            r_count <= '0;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_bo;
          r_acc <= {w_d, r_acc[WIDTH-1:1]};
          // Result stays hidden in r_acc until the MSB bit commits
          if (r_count == LAST) begin
            diff    <= {w_d, r_acc[WIDTH-1:1]};
            borrow  <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= r_br ^ w_bo;
`endif
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= DONE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases plus 1000 random back-to-back ops.
// Checks ovf as well when built with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_total = 0;
  int n_pass  = 0;

  logic [W-1:0] hold_diff;
  logic         hold_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_OVF_EN
    .borrow (borrow),
    .ovf    (ovf)
`else
    .borrow (borrow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: unsigned W+1-bit difference gives {borrow, diff}
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - (W+1)'(c);
  endfunction

  // Reference: signed overflow when the exact signed result leaves the W-bit range
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    return (s > 127) || (s < -128);
  endfunction

  // Advance negedge by negedge until done is seen; counts cycles and busy-high cycles
  task automatic wait_done(output int cyc, output int busy_n, output bit seen);
    cyc = 0; busy_n = 0; seen = 1'b0;
    while (cyc < 30) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_n++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] e;
    e = ref_sub(x, y, c);
    check({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
    check({tag, "_borrow"}, 32'(borrow), 32'(e[W]));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(ref_ovf(x, y, c)));
`endif
    hold_diff   = e[W-1:0];
    hold_borrow = e[W];
  endtask

  // Full directed op, starting and ending at a negedge with the DUT idle
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int cyc, busy_n;
    bit seen;
    a = x; b = y; bin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    @(negedge clk);
    check({tag, "_diff_held"}, 32'(diff), 32'(hold_diff));
    check({tag, "_borrow_held"}, 32'(borrow), 32'(hold_borrow));
    wait_done(cyc, busy_n, seen);
    check({tag, "_done_seen"}, 32'(seen), 32'(1));
    check({tag, "_latency"}, 32'(cyc), 32'(W));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    check_result(tag, x, y, c);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    int cyc, busy_n, extra;
    bit seen;
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic         qc[$];
    logic [W-1:0] ea, eb;
    logic         ec;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    hold_diff = '0; hold_borrow = 1'b0;
    #23;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_diff", 32'(diff), 32'(0));
    check("rst_borrow", 32'(borrow), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("t1", 8'h05, 8'h03, 1'b0);
    do_op("t2", 8'h03, 8'h05, 1'b0);
    do_op("t3a", 8'h00, 8'h00, 1'b1);
    do_op("t3b", 8'hFF, 8'hFF, 1'b0);

    // Start pulse mid-operation must be ignored
    a = 8'h20; b = 8'h05; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h10; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, busy_n, seen);
    check("t4_done_seen", 32'(seen), 32'(1));
    check("t4_latency", 32'(cyc + 3), 32'(W));
    check_result("t4", 8'h20, 8'h05, 1'b0);
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("t4_no_second_op", 32'(extra), 32'(0));

    // Reset mid-operation aborts with outputs cleared at once
    a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_done", 32'(done), 32'(0));
    check("t5_diff", 32'(diff), 32'(0));
    check("t5_borrow", 32'(borrow), 32'(0));
    hold_diff = '0; hold_borrow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t5_no_done_after_abort", 32'(extra), 32'(0));
    do_op("t5", 8'h0A, 8'h01, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    do_op("t6a", 8'h80, 8'h01, 1'b0);
    do_op("t6b", 8'h7F, 8'h01, 1'b0);
`endif

    // Random back-to-back ops with start held high
    ea = W'($urandom); eb = W'($urandom); ec = 1'($urandom);
    qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
    a = ea; b = eb; bin = ec; start = 1'b1;
    for (int op = 0; op < 1000; op++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done && cyc < 40);
      check("rnd_done_seen", 32'(done), 32'(1));
      check("rnd_spacing", 32'(cyc), (op == 0) ? 32'(W + 1) : 32'(W + 2));
      ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
      check_result("rnd", ea, eb, ec);
      if (!done) begin
        $display("FAIL rnd_timeout: no done within bound at op %0d", op);
        break;
      end
      if (op < 999) begin
        ea = W'($urandom); eb = W'($urandom); ec = 1'($urandom);
        qa.push_back(ea); qb.push_back(eb); qc.push_back(ec);
        a = ea; b = eb; bin = ec;
      end else begin
        start = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
